// File: rtl/bitslam_pkg.sv
// -----------------------------------------------------------------------------
// bitslam_pkg
// Shared definitions for the bitslam register-bus writer:
//   - bus field widths (6-bit address, 6-bit data)
//   - well-known register addresses of the bitslam voice core
//   - writer FSM state type and the packed FIFO entry type
// -----------------------------------------------------------------------------
package bitslam_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 6;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  // Clock-divider register of the voice core.
  localparam logic [ADDR_W-1:0] REG_CLK_DIV = 6'h00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    GAP
  } writer_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  function automatic wr_entry_t pack_entry(input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] data);
    wr_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/bitslam_reg_writer_if.sv
// -----------------------------------------------------------------------------
// bitslam_reg_writer_if
// Bundles the write-request handshake and the serial register bus.
//   wr_valid/wr_ready/wr_addr/wr_data : register write requests (host -> writer)
//   bus_sel/bus_val                   : serialised bus (writer -> voice core)
// Modports:
//   master : host side (drives requests, observes ready and the bus)
//   slave  : the writer itself
// -----------------------------------------------------------------------------
interface bitslam_reg_writer_if;
  import bitslam_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              bus_sel;
  logic [ADDR_W-1:0] bus_val;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready, bus_sel, bus_val
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready, bus_sel, bus_val
  );

endinterface

// File: rtl/bitslam_fifo.sv
// -----------------------------------------------------------------------------
// bitslam_fifo
// Small synchronous FIFO with show-ahead read (head_entry is valid whenever
// empty=0) so the writer can pop and use the entry on the same edge.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (flushes the FIFO)
//   push         : write push_entry on this edge (ignored when full)
//   push_entry   : entry to store
//   pop          : advance the head on this edge (ignored when empty)
//   head_entry   : oldest stored entry
//   full, empty  : occupancy flags
//   level        : occupancy, 0..DEPTH
// A pushed entry is only visible at the head after the push edge; there is no
// push-to-pop bypass. DEPTH must be a power of two so pointers wrap naturally.
// -----------------------------------------------------------------------------
module bitslam_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_entry,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [DEPTH-1:0] wr_en;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // One-hot write enable per storage slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem[i] <= push_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head_entry = mem[rd_ptr_reg];
  assign level      = level_reg;

endmodule

// File: rtl/bitslam_reg_writer.sv
// -----------------------------------------------------------------------------
// bitslam_reg_writer
// Host-side transmitter for the bitslam register bus. Register writes are
// accepted on a valid/ready port, buffered in a FIFO and serialised as an
// address phase (bus_sel=0) followed by a one-cycle data phase (bus_sel=1).
// Ports:
//   clk        : system clock, shared with the receiving voice core(s)
//   rst_n      : asynchronous active-low reset (abandons writes, flushes FIFO)
//   wif        : slave side of bitslam_reg_writer_if
//                (wr_valid/wr_ready/wr_addr/wr_data, bus_sel/bus_val)
//   busy       : FIFO non-empty or FSM not idle
//   fifo_level : current FIFO occupancy, 0..DEPTH
// Parameters:
//   DEPTH      : FIFO entries, power of two, 2..16
//   GAP_CYCLES : idle cycles inserted after each data phase, 0..15
// Optional feature macro: BITSLAM_ADDR_CACHE_EN
//   When defined, a write whose address equals the last address sent skips
//   its address phase (the core still holds that address).
// Receiver contract: while bus_sel=0 the core keeps re-latching bus_val as
// its address, so outside an address phase bus_val always holds the last
// address sent.
// -----------------------------------------------------------------------------
module bitslam_reg_writer
  import bitslam_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bitslam_reg_writer_if.slave     wif,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  wr_entry_t         head;
  wr_entry_t         push_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              dispatch_now;
  logic              cache_hit;

  writer_state_t     state_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic [DATA_W-1:0] cur_data_reg;
  logic [ADDR_W-1:0] last_addr_reg;
  logic              cache_valid_reg;
  logic [3:0]        gap_cnt_reg;
  logic              bus_sel_reg;
  logic [ADDR_W-1:0] bus_val_reg;

  assign push_entry = pack_entry(wif.wr_addr, wif.wr_data);

  bitslam_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (wif.wr_valid),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head_entry (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  // dispatch_now marks the edges on which the FSM is free to start the next
  // write: from IDLE, at the end of DATA when no gap is configured, and at the
  // end of the last gap cycle.
  always_comb begin
    dispatch_now = 1'b0;
    case (state_reg)
      IDLE:    dispatch_now = 1'b1;
      DATA:    dispatch_now = (GAP_CYCLES == 0);
      GAP:     dispatch_now = (gap_cnt_reg == GAP_LAST);
      default: dispatch_now = 1'b0;
    endcase
    fifo_pop = dispatch_now & ~fifo_empty;
`ifdef BITSLAM_ADDR_CACHE_EN
    cache_hit = cache_valid_reg && (head.addr == last_addr_reg);
`else
    cache_hit = 1'b0;
`endif
  end

  // Bus outputs are registered alongside the state: each transition loads the
  // value that the new state drives, so the bus shows a phase in the same
  // cycle the FSM is in it. last_addr is recorded on entry to DATA so that a
  // back-to-back pop at the end of DATA already compares against it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cur_addr_reg    <= '0;
      cur_data_reg    <= '0;
      last_addr_reg   <= '0;
      cache_valid_reg <= 1'b0;
      gap_cnt_reg     <= '0;
      bus_sel_reg     <= 1'b0;
      bus_val_reg     <= '0;
    end else if (fifo_pop) begin
      cur_addr_reg <= head.addr;
      cur_data_reg <= head.data;
      if (cache_hit) begin
        state_reg       <= DATA;
        bus_sel_reg     <= 1'b1;
        bus_val_reg     <= head.data;
        last_addr_reg   <= head.addr;
        cache_valid_reg <= 1'b1;
      end else begin
        state_reg   <= ADDR;
        bus_sel_reg <= 1'b0;
        bus_val_reg <= head.addr;
      end
    end else if (dispatch_now) begin
      state_reg   <= IDLE;
      bus_sel_reg <= 1'b0;
      bus_val_reg <= cache_valid_reg ? last_addr_reg : '0;
    end else begin
      case (state_reg)
        ADDR: begin
          state_reg       <= DATA;
          bus_sel_reg     <= 1'b1;
          bus_val_reg     <= cur_data_reg;
          last_addr_reg   <= cur_addr_reg;
          cache_valid_reg <= 1'b1;
        end
        DATA: begin
          // Only reached with GAP_CYCLES > 0.
          state_reg   <= GAP;
          gap_cnt_reg <= '0;
          bus_sel_reg <= 1'b0;
          bus_val_reg <= last_addr_reg;
        end
        GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 4'd1;
          bus_sel_reg <= 1'b0;
          bus_val_reg <= last_addr_reg;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign wif.wr_ready = ~fifo_full;
  assign wif.bus_sel  = bus_sel_reg;
  assign wif.bus_val  = bus_val_reg;
  assign busy         = ~fifo_empty | (state_reg != IDLE);

endmodule
